// File: rtl/key_code_if.sv
// Key-code bus between the front-panel encoder (master) and the parameter-step logic (slave).
// Carries the raw key state and repeat enables in, and the one-hot code pulse and lock flag out.
interface key_code_if;
    logic [15:0] key_vec;
    logic [15:0] repeat_mask;
    logic [15:0] data_out;
    logic        data_valid;
    logic        lock_err;

    modport master (
        input  key_vec,
        input  repeat_mask,
        output data_out,
        output data_valid,
        output lock_err
    );

    modport slave (
        output key_vec,
        output repeat_mask,
        input  data_out,
        input  data_valid,
        input  lock_err
    );
endinterface

// File: rtl/key_code_encoder.sv
// Debounced single-key encoder with per-key auto-repeat; emits one-tick one-hot row/col codes.
// Latency: first emit DEB_TICKS ticks after the first sample; no backpressure, consumer must take every pulse.
module key_code_encoder #(
    parameter int DEB_TICKS     = 1,
    parameter int REPEAT_DELAY  = 5,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic       clk_5Hz,
    input  logic       rst_n,
    key_code_if.master kc
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONFIRM = 3'd1,
        S_HOLD    = 3'd2,
        S_REPEAT  = 3'd3,
        S_LOCK    = 3'd4
    } state_t;

    localparam logic [3:0] DEB_LAST    = 4'(DEB_TICKS);
    localparam logic [3:0] DELAY_LAST  = 4'(REPEAT_DELAY - 1);
    localparam logic [3:0] PERIOD_LAST = 4'(REPEAT_PERIOD - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  in_idx;
    logic [3:0]  cnt_inc;
    logic        is_zero, is_single, same_key, emit;
    logic [15:0] code;

    assign is_zero   = (kc.key_vec == 16'h0000);
    assign is_single = !is_zero && ((kc.key_vec & (kc.key_vec - 16'd1)) == 16'h0000);
    assign same_key  = (kc.key_vec == (16'h0001 << idx_q));
    assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign code      = {8'h00, 4'b0001 << idx_q[3:2], 4'b0001 << idx_q[1:0]};

    // Only meaningful when is_single; picks the lone set bit.
    always_comb begin
        in_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (kc.key_vec[i]) in_idx = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        emit    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (is_single) begin
                    idx_d   = in_idx;
                    cnt_d   = 4'd1;
                    state_d = S_CONFIRM;
                end else if (!is_zero) begin
                    state_d = S_LOCK;
                end
            end
            S_CONFIRM: begin
                if (same_key) begin
                    if (cnt_q == DEB_LAST) begin
                        emit    = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (is_zero) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (is_single) begin
                    idx_d = in_idx;
                    cnt_d = 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = S_LOCK;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (same_key) begin
                    // Cleared mask freezes the counter: no emits until release.
                    if (kc.repeat_mask[idx_q]) begin
                        if (cnt_q == ((state_q == S_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
                            emit    = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = S_REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end else if (is_zero) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (is_zero) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_5Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            idx_q         <= 4'd0;
            kc.data_out   <= 16'h0000;
            kc.data_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            kc.data_out   <= emit ? code : 16'h0000;
            kc.data_valid <= emit;
        end
    end

    assign kc.lock_err = (state_q == S_LOCK);

endmodule

// File: tb/tb_key_code_encoder.sv
// Directed bench for key_code_encoder with default parameters (DEB 1, delay 5, period 1).
module tb_key_code_encoder;
    logic clk_5Hz = 1'b0;
    logic rst_n   = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    key_code_if bus ();

    key_code_encoder dut (
        .clk_5Hz (clk_5Hz),
        .rst_n   (rst_n),
        .kc      (bus)
    );

    always #5 clk_5Hz = ~clk_5Hz;

    task automatic tick();
        @(posedge clk_5Hz);
        #1;
    endtask

    task automatic go_idle();
        bus.key_vec = 16'h0000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        bus.key_vec     = 16'h0001;
        bus.repeat_mask = 16'h0000;
        rst_n           = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.data_out !== 16'h0000 || bus.data_valid !== 1'b0 || bus.lock_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: got data=%h valid=%b lock=%b, want 0000/0/0",
                         bus.data_out, bus.data_valid, bus.lock_err);
            end
        end
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_cmp++;
            if (bus.data_out !== ((t == 1) ? 16'h0011 : 16'h0000) || bus.data_valid !== (t == 1)) begin
                n_bad++;
                $display("FAIL reset_release t=%0d: got data=%h valid=%b, want data=%h valid=%b",
                         t, bus.data_out, bus.data_valid, (t == 1) ? 16'h0011 : 16'h0000, (t == 1));
            end
        end
        go_idle();
    endtask

    task automatic test_tap();
        bus.repeat_mask = 16'h0000;
        bus.key_vec     = 16'h0020;
        for (int t = 0; t < 3; t++) begin
            if (t == 2) bus.key_vec = 16'h0000;
            tick();
            n_cmp++;
            if (bus.data_out !== ((t == 1) ? 16'h0022 : 16'h0000) || bus.data_valid !== (t == 1)) begin
                n_bad++;
                $display("FAIL tap2 t=%0d: got data=%h valid=%b, want data=%h valid=%b",
                         t, bus.data_out, bus.data_valid, (t == 1) ? 16'h0022 : 16'h0000, (t == 1));
            end
        end
        go_idle();
        bus.key_vec = 16'h0020;
        for (int t = 0; t < 3; t++) begin
            if (t == 1) bus.key_vec = 16'h0000;
            tick();
            n_cmp++;
            if (bus.data_out !== 16'h0000 || bus.data_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL tap1 t=%0d: got data=%h valid=%b, want 0000/0",
                         t, bus.data_out, bus.data_valid);
            end
        end
        go_idle();
    endtask

    task automatic test_hold_repeat();
        logic        exp_v;
        logic [15:0] exp_d;
        bus.repeat_mask = 16'h0010;
        bus.key_vec     = 16'h0010;
        for (int t = 0; t < 13; t++) begin
            if (t == 12) bus.key_vec = 16'h0000;
            tick();
            exp_v = (t == 1) || (t >= 6 && t <= 11);
            exp_d = exp_v ? 16'h0021 : 16'h0000;
            n_cmp++;
            if (bus.data_out !== exp_d || bus.data_valid !== exp_v || bus.lock_err !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_repeat t=%0d: got data=%h valid=%b lock=%b, want data=%h valid=%b lock=0",
                         t, bus.data_out, bus.data_valid, bus.lock_err, exp_d, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_mask_off_mid_repeat();
        logic exp_v;
        bus.repeat_mask = 16'h0010;
        bus.key_vec     = 16'h0010;
        for (int t = 0; t < 11; t++) begin
            if (t == 8) bus.repeat_mask = 16'h0000;
            tick();
            exp_v = (t == 1) || (t == 6) || (t == 7);
            n_cmp++;
            if (bus.data_out !== (exp_v ? 16'h0021 : 16'h0000) || bus.data_valid !== exp_v) begin
                n_bad++;
                $display("FAIL mask_off t=%0d: got data=%h valid=%b, want valid=%b",
                         t, bus.data_out, bus.data_valid, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_no_repeat();
        logic exp_v;
        bus.repeat_mask = 16'hFFFE;
        bus.key_vec     = 16'h0001;
        for (int t = 0; t < 10; t++) begin
            tick();
            exp_v = (t == 1);
            n_cmp++;
            if (bus.data_out !== (exp_v ? 16'h0011 : 16'h0000) || bus.data_valid !== exp_v) begin
                n_bad++;
                $display("FAIL no_repeat t=%0d: got data=%h valid=%b, want valid=%b",
                         t, bus.data_out, bus.data_valid, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_lock();
        bus.repeat_mask = 16'h0000;
        bus.key_vec     = 16'h0002;
        tick();
        tick();
        n_cmp++;
        if (bus.data_out !== 16'h0012 || bus.data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_pre: got data=%h valid=%b, want 0012/1", bus.data_out, bus.data_valid);
        end
        for (int t = 0; t < 6; t++) begin
            bus.key_vec = (t < 3) ? 16'h0006 : 16'h0002;
            tick();
            n_cmp++;
            if (bus.lock_err !== 1'b1 || bus.data_valid !== 1'b0 || bus.data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL lock_hold t=%0d: got lock=%b valid=%b data=%h, want 1/0/0000",
                         t, bus.lock_err, bus.data_valid, bus.data_out);
            end
        end
        bus.key_vec = 16'h0000;
        tick();
        n_cmp++;
        if (bus.lock_err !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_exit: got lock=%b, want 0", bus.lock_err);
        end
        bus.key_vec = 16'h0002;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_cmp++;
            if (bus.data_out !== ((t == 1) ? 16'h0012 : 16'h0000) || bus.data_valid !== (t == 1)) begin
                n_bad++;
                $display("FAIL lock_repress t=%0d: got data=%h valid=%b, want valid=%b",
                         t, bus.data_out, bus.data_valid, (t == 1));
            end
        end
        go_idle();
    endtask

    task automatic test_relatch();
        bus.repeat_mask = 16'h0000;
        bus.key_vec     = 16'h0008;
        for (int t = 0; t < 4; t++) begin
            if (t == 1) bus.key_vec = 16'h8000;
            tick();
            n_cmp++;
            if (bus.data_out !== ((t == 2) ? 16'h0088 : 16'h0000) || bus.data_valid !== (t == 2)) begin
                n_bad++;
                $display("FAIL relatch t=%0d: got data=%h valid=%b, want data=%h valid=%b",
                         t, bus.data_out, bus.data_valid, (t == 2) ? 16'h0088 : 16'h0000, (t == 2));
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_repeat();
        bus.repeat_mask = 16'h0010;
        bus.key_vec     = 16'h0010;
        for (int t = 0; t < 8; t++) tick();
        n_cmp++;
        if (bus.data_out !== 16'h0021 || bus.data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre: got data=%h valid=%b, want 0021/1", bus.data_out, bus.data_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.data_out !== 16'h0000 || bus.data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_async: got data=%h valid=%b, want 0000/0", bus.data_out, bus.data_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick();
            n_cmp++;
            if (bus.data_out !== ((t == 1) ? 16'h0021 : 16'h0000) || bus.data_valid !== (t == 1)) begin
                n_bad++;
                $display("FAIL abort_restart t=%0d: got data=%h valid=%b, want valid=%b",
                         t, bus.data_out, bus.data_valid, (t == 1));
            end
        end
        go_idle();
    endtask

    initial begin
        bus.key_vec     = 16'h0000;
        bus.repeat_mask = 16'h0000;
        test_reset();
        test_tap();
        test_hold_repeat();
        test_mask_off_mid_repeat();
        test_no_repeat();
        test_lock();
        test_relatch();
        test_reset_mid_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_code_encoder.md
Name: key_code_encoder

Overview:
- Converts the 16-key front-panel matrix into the 16-bit one-hot key codes consumed by the parameter-step logic (mode, fs, fc, ma steps) on the clk_5Hz domain.
- This is the producer side of that key-code interface. It provides debounce confirmation, single-key enforcement, per-key auto-repeat and a one-tick code pulse, so one press gives exactly one step.

Parameters:
- DEB_TICKS, 1, consecutive extra samples of an identical single key required before the first emit (1..7).
- REPEAT_DELAY, 5, ticks from the first emit to the first auto-repeat emit (2..15; 5 = 1 s).
- REPEAT_PERIOD, 1, ticks between subsequent auto-repeat emits (1..15).

Ports:
- clk_5Hz  input  1  0.2 s tick clock.
- rst_n  input  1  asynchronous, active-low reset.
- key_vec  input  16  level key-state vector, already synchronous to clk_5Hz. Bit i = key i pressed; row = i[3:2], col = i[1:0].
- repeat_mask  input  16  bit i = 1 enables auto-repeat for key i.
- data_out  output  16  key code during an emit tick, else 16'h0000.
- data_valid  output  1  high exactly during emit ticks.
- lock_err  output  1  high while in LOCK.

Behaviour:
- Reset (async, rst_n low): state IDLE, counters 0, key index 0, data_out 16'h0000, data_valid 0, lock_err 0. Reset mid-hold or mid-repeat aborts immediately with no emit.
- Code format: data_out = {8'h00, onehot4(row), onehot4(col)}.
  - onehot4(n) = 4'b0001 << n.
  - Key 0 -> 16'h0011, key 1 -> 16'h0012, key 4 -> 16'h0021, key 15 -> 16'h0088.
- Outputs are registered. data_out and data_valid are nonzero/high only in the cycle after an emit edge and return to 0/0 on the next edge unless that edge also emits.
- "single" means key_vec has exactly one bit set. "multi" means two or more bits set.
- States: IDLE, CONFIRM, HOLD, REPEAT, LOCK.
- IDLE:
  - zero -> stay.
  - single -> latch the index, cnt = 1, go to CONFIRM.
  - multi -> go to LOCK.
- CONFIRM:
  - Same key: if cnt == DEB_TICKS, emit, cnt = 0, go to HOLD. Otherwise cnt++.
  - Zero -> IDLE, no emit.
  - Different single key -> relatch that key, cnt = 1, stay in CONFIRM.
  - Multi -> LOCK.
- HOLD:
  - Same key with repeat_mask[idx] = 1: cnt++. When cnt reaches REPEAT_DELAY-1, emit instead, set cnt = 0, go to REPEAT.
  - Same key with repeat_mask[idx] = 0: stay, no emit.
  - Zero -> IDLE.
  - Any other nonzero value -> LOCK.
- REPEAT:
  - Same key: cnt++. When cnt reaches REPEAT_PERIOD-1, emit and set cnt = 0.
  - With REPEAT_PERIOD = 1, every tick emits and data_out stays continuously equal to the code.
  - Zero -> IDLE.
  - Other nonzero value -> LOCK.
  - A repeat_mask[idx] 1->0 change while in REPEAT: no further emits; stay until release.
- LOCK:
  - lock_err = 1, no emits.
  - Leave to IDLE only on a tick with key_vec == 0.
  - A subsequent single press must pass CONFIRM again.
- Latency: press first sampled at edge N -> first emit visible after edge N+DEB_TICKS.
  - First repeat emit: REPEAT_DELAY ticks after the first emit.
  - Later repeats: every REPEAT_PERIOD ticks.
- Release on the same edge a repeat would fire: release wins, no emit.
- Counters are 4 bits and saturate; they are never allowed to wrap.
- No emit is ever produced for multi or zero states.

Test Plan:
- Reset with key_vec = 16'h0001 held: outputs stay 0 during reset. Release reset at edge N: data_out = 16'h0011, data_valid = 1 only in the cycle after edge N+1, then 0.
- Tap key 5 for 2 ticks, mask = 0: exactly one pulse of 16'h0022. Tap for 1 tick only: no pulse.
- Hold key 4 (mask bit 4 = 1) for 12 ticks with defaults: pulses at ticks 1, 6, 7, 8, 9, 10, 11 relative to the first sample, each 16'h0021. Release: outputs 0, state IDLE.
- Hold key 0 with mask bit 0 = 0 for 10 ticks: exactly one 16'h0011 pulse.
- Press key 1, then keys 1 and 2 together during HOLD: lock_err = 1, no pulses. Drop back to key 1 alone: still locked. key_vec = 0 -> lock_err = 0. Press key 1 again -> fresh 16'h0012 after DEB_TICKS.
- CONFIRM with key 3 changing to key 15 at cnt = 1: relatch; emit 16'h0088 one tick later, never 16'h0018.
